// File: rtl/ae_pkg.sv
// Shared constants for the neuron-lane stream fabric: default data width,
// channel limit and the demux routing-mode encodings.
package ae_pkg;
    localparam int   DATA_W        = 16;
    localparam int   MAX_CH        = 16;
    localparam logic MODE_EXPLICIT = 1'b0;
    localparam logic MODE_AUTO     = 1'b1;
endpackage

// File: rtl/demux_1_n_stream_if.sv
// Stream bundle for the 1-to-N demux: one input valid/ready port and N
// flattened output lanes. slave is the demux view, master the environment view.
interface demux_1_n_stream_if #(
    parameter int WIDTH = 16,
    parameter int N_CH  = 4
);
    logic [WIDTH-1:0]      in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [N_CH*WIDTH-1:0] out_data;
    logic [N_CH-1:0]       out_valid;
    logic [N_CH-1:0]       out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/demux_ch_slot.sv
// One-entry holding register for a single demux output lane.
// Data is kept (not zeroed) after the consumer drains the valid flag.
module demux_ch_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // A load in the same cycle as a drain keeps the lane full with the new word.
    always_comb begin
        data_d  = load ? in_data : data_q;
        valid_d = load | (valid_q & ~out_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
endmodule

// File: rtl/demux_1_n_stream.sv
// 1-to-N valid/ready stream demux with explicit or auto-sequential lane select.
// Optional frame_done pulse enabled by defining DEMUX_FRAME_DONE_EN.
module demux_1_n_stream
    import ae_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [SEL_W-1:0] select,
    input  logic             ptr_clr,
    demux_1_n_stream_if.slave bus,
    output logic [SEL_W-1:0] ptr,
    output logic             sel_err
`ifdef DEMUX_FRAME_DONE_EN
    ,
    output logic             frame_done
`endif
);
    logic [SEL_W-1:0] tgt;
    logic             in_range;
    logic             rdy;
    logic             accept;
    logic             auto_mode;
    logic [N_CH-1:0]  load;
    logic [N_CH-1:0]  slot_valid;
    logic [WIDTH-1:0] slot_data [N_CH];

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             sel_err_q, sel_err_d;

    assign auto_mode = (mode == MODE_AUTO);

    // Out-of-range targets (non power-of-2 N_CH only) are always ready and dropped.
    always_comb begin
        tgt      = auto_mode ? ptr_q : select;
        in_range = ({1'b0, tgt} < (SEL_W+1)'(N_CH));
        rdy      = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
            if (tgt == SEL_W'(k)) rdy = ~slot_valid[k] | bus.out_ready[k];
        end
    end

    assign bus.in_ready = rdy;
    assign accept       = bus.in_valid & rdy;

    always_comb begin
        load = '0;
        for (int k = 0; k < N_CH; k++) begin
            load[k] = accept & (tgt == SEL_W'(k));
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        demux_ch_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[k]),
            .in_data   (bus.in_data),
            .out_ready (bus.out_ready[k]),
            .out_data  (slot_data[k]),
            .out_valid (slot_valid[k])
        );
        assign bus.out_data[k*WIDTH +: WIDTH] = slot_data[k];
    end

    assign bus.out_valid = slot_valid;

    // Clear wins over advance; a colliding word still used the old pointer.
    always_comb begin
        ptr_d = ptr_q;
        if (ptr_clr) begin
            ptr_d = '0;
        end else if (accept && auto_mode) begin
            ptr_d = (ptr_q == SEL_W'(N_CH-1)) ? '0 : ptr_q + SEL_W'(1);
        end
        sel_err_d = accept & ~in_range;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign ptr     = ptr_q;
    assign sel_err = sel_err_q;

`ifdef DEMUX_FRAME_DONE_EN
    logic frame_done_q, frame_done_d;

    assign frame_done_d = accept & auto_mode & (ptr_q == SEL_W'(N_CH-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_done_q <= 1'b0;
        else     frame_done_q <= frame_done_d;
    end

    assign frame_done = frame_done_q;
`endif
endmodule

// File: tb/tb_demux_1_n_stream.sv
// Bench for demux_1_n_stream: a 4-lane and a 3-lane instance share stimulus
// and are compared every cycle against an array-based lane model.
module tb_demux_1_n_stream;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_valid, s_mode, s_clr;
    logic [15:0] s_data;
    logic [1:0]  s_sel;
    logic [3:0]  s_ordy;

    demux_1_n_stream_if #(.WIDTH(16), .N_CH(4)) if_a ();
    demux_1_n_stream_if #(.WIDTH(16), .N_CH(3)) if_b ();

    assign if_a.in_valid  = s_valid;
    assign if_a.in_data   = s_data;
    assign if_a.out_ready = s_ordy;
    assign if_b.in_valid  = s_valid;
    assign if_b.in_data   = s_data;
    assign if_b.out_ready = s_ordy[2:0];

    logic [1:0] ptr_a, ptr_b;
    logic       err_a, err_b;
`ifdef DEMUX_FRAME_DONE_EN
    logic       fd_a, fd_b;
`endif

    demux_1_n_stream #(.WIDTH(16), .N_CH(4)) u_dut_a (
        .clk(clk), .rst(rst), .mode(s_mode), .select(s_sel), .ptr_clr(s_clr),
        .bus(if_a), .ptr(ptr_a), .sel_err(err_a)
`ifdef DEMUX_FRAME_DONE_EN
        , .frame_done(fd_a)
`endif
    );

    demux_1_n_stream #(.WIDTH(16), .N_CH(3)) u_dut_b (
        .clk(clk), .rst(rst), .mode(s_mode), .select(s_sel), .ptr_clr(s_clr),
        .bus(if_b), .ptr(ptr_b), .sel_err(err_b)
`ifdef DEMUX_FRAME_DONE_EN
        , .frame_done(fd_b)
`endif
    );

    // Reference model: per-design lane contents, full flags, pointer and pulses.
    logic [15:0] m_d   [2][4];
    logic        m_v   [2][4];
    int          m_ptr [2];
    logic        m_err [2];
    logic        m_fd  [2];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic logic model_rdy(input int d);
        int t;
        t = s_mode ? m_ptr[d] : int'(s_sel);
        if (t >= nch(d)) return 1'b1;
        return !m_v[d][t] || s_ordy[t];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                m_d[d][k] = 16'h0;
                m_v[d][k] = 1'b0;
            end
            m_ptr[d] = 0;
            m_err[d] = 1'b0;
            m_fd[d]  = 1'b0;
        end
    endtask

    task automatic model_adv();
        for (int d = 0; d < 2; d++) begin
            int   n, t;
            logic acc;
            n   = nch(d);
            t   = s_mode ? m_ptr[d] : int'(s_sel);
            acc = s_valid && model_rdy(d);
            for (int k = 0; k < n; k++) begin
                if (m_v[d][k] && s_ordy[k]) m_v[d][k] = 1'b0;
            end
            if (acc && t < n) begin
                m_d[d][t] = s_data;
                m_v[d][t] = 1'b1;
            end
            m_err[d] = acc && (t >= n);
            m_fd[d]  = acc && s_mode && (m_ptr[d] == n - 1);
            if (s_clr)              m_ptr[d] = 0;
            else if (acc && s_mode) m_ptr[d] = (m_ptr[d] + 1) % n;
        end
    endtask

    function automatic logic [63:0] exp_data(input int d);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < nch(d); k++) r[k*16 +: 16] = m_d[d][k];
        return r;
    endfunction

    function automatic logic [63:0] exp_valid(input int d);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < nch(d); k++) r[k] = m_v[d][k];
        return r;
    endfunction

    task automatic check_out();
        chk("a_valid", 64'(if_a.out_valid), exp_valid(0));
        chk("b_valid", 64'(if_b.out_valid), exp_valid(1));
        chk("a_data",  64'(if_a.out_data),  exp_data(0));
        chk("b_data",  64'(if_b.out_data),  exp_data(1));
        chk("a_ptr",   64'(ptr_a), 64'(m_ptr[0]));
        chk("b_ptr",   64'(ptr_b), 64'(m_ptr[1]));
        chk("a_err",   64'(err_a), 64'(m_err[0]));
        chk("b_err",   64'(err_b), 64'(m_err[1]));
`ifdef DEMUX_FRAME_DONE_EN
        chk("a_fd",    64'(fd_a),  64'(m_fd[0]));
        chk("b_fd",    64'(fd_b),  64'(m_fd[1]));
`endif
    endtask

    // One clock of stimulus: drive after the falling edge, check in_ready
    // before the rising edge, check registered outputs just after it.
    task automatic step(input logic v, input logic [15:0] dat, input logic md,
                        input logic [1:0] sel, input logic clr, input logic [3:0] ordy,
                        output logic ra, output logic rb);
        @(negedge clk);
        s_valid = v; s_data = dat; s_mode = md; s_sel = sel; s_clr = clr; s_ordy = ordy;
        #1;
        ra = if_a.in_ready;
        rb = if_b.in_ready;
        chk("a_rdy", 64'(ra), 64'(model_rdy(0)));
        chk("b_rdy", 64'(rb), 64'(model_rdy(1)));
        model_adv();
        @(posedge clk);
        #1;
        check_out();
    endtask

    logic ra, rb;
    int   fd_cnt;

    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_data = '0; s_mode = 1'b0; s_sel = '0; s_clr = 1'b0; s_ordy = 4'hF;
        model_reset();
        @(negedge clk);
        #1;
        check_out();
        chk("rst_rdy_a", 64'(if_a.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Explicit routing
        step(1'b1, 16'h0011, 1'b0, 2'd3, 1'b0, 4'hF, ra, rb);
        step(1'b1, 16'h0022, 1'b0, 2'd0, 1'b0, 4'hF, ra, rb);
        step(1'b1, 16'h0033, 1'b0, 2'd2, 1'b0, 4'hF, ra, rb);
        step(1'b1, 16'h0044, 1'b0, 2'd1, 1'b0, 4'hF, ra, rb);
        chk("route_valid", 64'(if_a.out_valid), 64'h2);
        chk("route_lane1", 64'(if_a.out_data[31:16]), 64'h0044);
        chk("route_lane3", 64'(if_a.out_data[63:48]), 64'h0011);
        step(1'b0, 16'h0, 1'b0, 2'd0, 1'b0, 4'hF, ra, rb);

        // Backpressure on lane 1
        step(1'b1, 16'hAAAA, 1'b0, 2'd1, 1'b0, 4'b1101, ra, rb);
        chk("bp_first_rdy", 64'(ra), 64'd1);
        step(1'b1, 16'hBBBB, 1'b0, 2'd1, 1'b0, 4'b1101, ra, rb);
        chk("bp_stall_rdy", 64'(ra), 64'd0);
        chk("bp_hold_data", 64'(if_a.out_data[31:16]), 64'hAAAA);
        step(1'b1, 16'hBBBB, 1'b0, 2'd1, 1'b0, 4'hF, ra, rb);
        chk("bp_release_rdy", 64'(ra), 64'd1);
        chk("bp_release_vld", 64'(if_a.out_valid[1]), 64'd1);
        chk("bp_release_data", 64'(if_a.out_data[31:16]), 64'hBBBB);
        step(1'b0, 16'h0, 1'b0, 2'd0, 1'b0, 4'hF, ra, rb);

        // Auto wrap
        step(1'b0, 16'h0, 1'b1, 2'd0, 1'b1, 4'hF, ra, rb);
        fd_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 16'(i), 1'b1, 2'd0, 1'b0, 4'hF, ra, rb);
`ifdef DEMUX_FRAME_DONE_EN
            if (fd_a) fd_cnt++;
`endif
        end
        chk("wrap_ptr", 64'(ptr_a), 64'd1);
        chk("wrap_lane0", 64'(if_a.out_data[15:0]), 64'd5);
        chk("wrap_lane3", 64'(if_a.out_data[63:48]), 64'd4);
`ifdef DEMUX_FRAME_DONE_EN
        chk("wrap_fd_count", 64'(fd_cnt), 64'd1);
`endif

        // ptr_clr colliding with an accept
        step(1'b1, 16'h0066, 1'b1, 2'd0, 1'b0, 4'hF, ra, rb);
        chk("coll_pre_ptr", 64'(ptr_a), 64'd2);
        step(1'b1, 16'h0077, 1'b1, 2'd0, 1'b1, 4'hF, ra, rb);
        chk("coll_lane2", 64'(if_a.out_data[47:32]), 64'h0077);
        chk("coll_ptr", 64'(ptr_a), 64'd0);

        // Out-of-range explicit select on the 3-lane instance
        step(1'b0, 16'h0, 1'b0, 2'd0, 1'b0, 4'hF, ra, rb);
        step(1'b1, 16'h0099, 1'b0, 2'd3, 1'b0, 4'hF, ra, rb);
        chk("oor_rdy", 64'(rb), 64'd1);
        chk("oor_err", 64'(err_b), 64'd1);
        chk("oor_no_load", 64'(if_b.out_valid), 64'd0);
        step(1'b0, 16'h0, 1'b0, 2'd0, 1'b0, 4'hF, ra, rb);
        chk("oor_err_single", 64'(err_b), 64'd0);

        // Fill lanes and move the pointer, then reset mid-cycle
        step(1'b1, 16'h1234, 1'b1, 2'd0, 1'b0, 4'h0, ra, rb);
        step(1'b1, 16'h5678, 1'b1, 2'd0, 1'b0, 4'h0, ra, rb);
        step(1'b1, 16'h9ABC, 1'b0, 2'd2, 1'b0, 4'h0, ra, rb);
        s_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(if_a.out_valid), 64'd0);
        chk("mid_rst_data", 64'(if_a.out_data), 64'd0);
        chk("mid_rst_ptr", 64'(ptr_a), 64'd0);
        chk("mid_rst_valid_b", 64'(if_b.out_valid), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 16'h0, 1'b0, 2'd1, 1'b0, 4'h0, ra, rb);
        chk("post_rst_rdy", 64'(ra), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 1) == 1,
                 2'($urandom), $urandom_range(0, 15) == 0, 4'($urandom), ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/demux_1_n_stream.md
# demux_1_n_stream

Parametrised 1-to-N streaming demultiplexer. It routes 16-bit fixed-point words from one producer to N neuron-lane consumers using a valid/ready handshake. Each output channel has a one-entry holding register, so a stalled lane never corrupts another lane's data. The target lane is set either by an explicit select or by an internal wrapping sequencer, so a layer input vector can be scattered across lanes without external counters.

## Interface
Parameters:
- WIDTH, 16: data width in bits (Q-format agnostic).
- N_CH, 4: number of output channels; legal range 2..16.
- SEL_W, $clog2(N_CH): select/pointer width; derived, not overridden.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = explicit select, 1 = auto-sequential.
- select  in  SEL_W  target channel in explicit mode; ignored in auto mode.
- ptr_clr  in  1  synchronous clear of the auto pointer.
- in_data  in  WIDTH  input word.
- in_valid  in  1  input word present.
- in_ready  out  1  input accepted when in_valid & in_ready.
- out_data  out  N_CH*WIDTH  flattened; channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  N_CH  per-channel holding register full.
- out_ready  in  N_CH  per-channel consumer ready.
- ptr  out  SEL_W  current auto pointer.
- sel_err  out  1  one-cycle pulse when an out-of-range explicit select is accepted.
- frame_done  out  1  present only with DEMUX_FRAME_DONE_EN.

## Operation
- Target selection: tgt = mode ? ptr : select.
- Range check: tgt is out of range when tgt >= N_CH. This can only happen in explicit mode with non-power-of-2 N_CH.
- in_ready:
  - tgt in range: in_ready = ~out_valid[tgt] | out_ready[tgt]. This is a combinational path from out_ready.
  - tgt out of range: in_ready = 1, the word is discarded, and sel_err pulses the next cycle.
- On accept to channel k: slot k loads in_data and out_valid[k] is set. Other channels are unchanged.
- Channel drain: when out_valid[k] & out_ready[k], out_valid[k] clears, unless the same cycle also loads k; then it stays set with the new data.
- Slot data while out_valid[k] = 0: out_data slot k holds its last value (not zeroed).
- Auto pointer:
  - Advances by 1 on every accept in auto mode.
  - Wraps from N_CH-1 to 0.
  - Does not advance in explicit mode.
- ptr_clr sets ptr to 0 and has priority over advance. If ptr_clr and an accept coincide, the word goes to the old ptr and then ptr = 0.
- Mode change mid-stream: ptr is retained; no slot is flushed.
- No state machine beyond the pointer and N valid flags.

## Timing
- Latency: accept at edge t gives out_valid[k] = 1 and data visible after edge t.
- Throughput: 1 word per cycle when consumers are always ready. A lane held not-ready stalls only input words that target it.
- Reset values:
  - out_valid = 0, out_data = 0, ptr = 0, sel_err = 0, frame_done = 0.
  - in_ready follows the combinational rule from reset state, so it is 1 for any in-range tgt.
- Reset asserted mid-transfer: all held words are lost and no output pulses are generated.
- sel_err and frame_done are registered single-cycle pulses.

## Configuration
- DEMUX_FRAME_DONE_EN defined:
  - frame_done port exists.
  - It pulses one cycle after an auto-mode accept with ptr = N_CH-1, i.e. after a full vector has been scattered.
  - ptr_clr does not generate a pulse.
- Not defined: the port and its register are absent. All other behaviour is identical.

## Structure
- Shared package ae_pkg holds:
  - DATA_W = 16
  - MAX_CH = 16
  - mode encodings MODE_EXPLICIT = 1'b0 and MODE_AUTO = 1'b1
- Sub-module demux_ch_slot: one holding register with load/drain/valid logic, parameter WIDTH. It is instantiated N_CH times in a generate loop.
- Top level holds: target mux, range check, in_ready mux, pointer and pulse registers.

## Test plan
- Reset: assert rst asynchronously mid-cycle with slots full → out_valid = 0, ptr = 0, out_data = 0 immediately. After release, in_ready = 1.
- Explicit routing: N_CH = 4, all out_ready = 1, words 0x0011/0x0022/0x0033/0x0044 to select 3/0/2/1 → each appears on the matching lane one cycle later; other lanes stay valid = 0.
- Backpressure: out_ready[1] = 0, two words to select 1 → first held; in_ready = 0 for the second. Raise out_ready[1] → second accepted in the same cycle; out_valid[1] stays 1 with the new data.
- Auto wrap: mode = 1, 5 consecutive words 1..5 → lanes 0,1,2,3,0 get 1,2,3,4,5 and ptr returns to 1. With DEMUX_FRAME_DONE_EN, one frame_done pulse after word 4.
- ptr_clr collision: ptr = 2, accept plus ptr_clr in the same cycle → word lands on lane 2, and ptr = 0 next cycle.
- Out-of-range: N_CH = 3, select = 3, in_valid = 1 → in_ready = 1, no lane loads, sel_err pulses once.
